// File: rtl/pcs_link_ctrl.sv
// pcs_link_ctrl: 1000BASE-X PCS link bring-up sequencer.
// Drives the shared one-hot xmit mode bus (CONFIG/IDLE/DATA). Mode changes
// out of DATA are held off while a frame is in flight, except on loss of sync.
// Reset is asynchronous on assertion; its release is expected to be
// synchronised to GTX_CLK upstream.
//
// state       | meaning
// ------------+---------------------------------------------------------
// LINK_DOWN   | no sync/signal or management restart held; send /C/
// CONFIG_WAIT | sending /C/, waiting for LINK_TIMER cycles of partner /C/
// IDLE_DETECT | sending /I/, waiting for LINK_TIMER cycles of partner /I/
// LINK_OK     | data mode; restarts deferred until the frame completes

module pcs_link_ctrl #(
  parameter int unsigned LINK_TIMER = 1024,
  parameter int unsigned CNT_W      = 20
) (
  input  logic       GTX_CLK,
  input  logic       mr_main_reset,
  input  logic       signal_detect,
  input  logic       code_sync_status,
  input  logic       mr_restart,
  input  logic       rx_config_det,
  input  logic       rx_idle_det,
  input  logic       transmitting,
  input  logic       receiving,
  output logic [2:0] xmit,
  output logic       mr_link_ok,
  output logic [1:0] link_state,
  output logic [7:0] link_fail_cnt
);

  typedef enum logic [1:0] {
    LINK_DOWN   = 2'b00,
    CONFIG_WAIT = 2'b01,
    IDLE_DETECT = 2'b10,
    LINK_OK     = 2'b11
  } state_t;

  localparam logic [2:0] XMIT_CONFIG = 3'b001;
  localparam logic [2:0] XMIT_IDLE   = 3'b010;
  localparam logic [2:0] XMIT_DATA   = 3'b100;

  // The qualification timer counts down from LINK_TIMER-1; reaching zero with
  // the qualifier still high is the LINK_TIMER-th consecutive qualifying cycle.
  localparam logic [CNT_W-1:0] TMR_RELOAD = CNT_W'(LINK_TIMER - 1);
  localparam logic [CNT_W-1:0] TMR_ONE    = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] tmr_q, tmr_d;
  logic             pend_down_q, pend_down_d;
  logic             pend_cfg_q, pend_cfg_d;
  logic [7:0]       fail_cnt_d;
  logic [2:0]       xmit_d;
  logic             link_ok_d;

  logic up;
  logic busy;
  logic qual;
  logic expiry;
  logic want_down;
  logic want_cfg;

  assign up     = signal_detect & code_sync_status;
  assign busy   = transmitting | receiving;
  assign expiry = qual && (tmr_q == '0);

  // Select the input that qualifies the timer in the current state.
  always_comb begin
    qual = 1'b0;
    unique case (state_q)
      CONFIG_WAIT: qual = rx_config_det;
      IDLE_DETECT: qual = rx_idle_det;
      default:     qual = 1'b0;
    endcase
  end

  // Next-state, deferred-restart bookkeeping, timer and output decode.
  always_comb begin
    state_d     = state_q;
    pend_down_d = pend_down_q;
    pend_cfg_d  = pend_cfg_q;
    want_down   = mr_restart | pend_down_q;
    want_cfg    = rx_config_det | pend_cfg_q;
    tmr_d       = TMR_RELOAD;
    fail_cnt_d  = link_fail_cnt;
    xmit_d      = XMIT_CONFIG;
    link_ok_d   = 1'b0;

    if (!up) begin
      state_d = LINK_DOWN;
    end else if (mr_restart && (state_q != LINK_OK)) begin
      state_d = LINK_DOWN;
    end else begin
      unique case (state_q)
        LINK_DOWN: begin
          state_d = CONFIG_WAIT;
        end
        CONFIG_WAIT: begin
          if (expiry) state_d = IDLE_DETECT;
        end
        IDLE_DETECT: begin
          // Partner falling back to /C/ outranks a simultaneous expiry.
          if (rx_config_det)  state_d = CONFIG_WAIT;
          else if (expiry)    state_d = LINK_OK;
        end
        LINK_OK: begin
          if (!busy) begin
            if (want_down)     state_d = LINK_DOWN;
            else if (want_cfg) state_d = CONFIG_WAIT;
          end else begin
            pend_down_d = want_down;
            pend_cfg_d  = want_cfg;
          end
        end
        default: state_d = LINK_DOWN;
      endcase
    end

    if (state_d != LINK_OK) begin
      pend_down_d = 1'b0;
      pend_cfg_d  = 1'b0;
    end

    // Any state entry or a dropped qualifier restarts the count.
    if ((state_d == state_q) && qual) begin
      tmr_d = tmr_q - TMR_ONE;
    end

    if ((state_q == LINK_OK) && (state_d != LINK_OK) && (link_fail_cnt != 8'hFF)) begin
      fail_cnt_d = link_fail_cnt + 8'd1;
    end

    unique case (state_d)
      IDLE_DETECT: xmit_d = XMIT_IDLE;
      LINK_OK:     xmit_d = XMIT_DATA;
      default:     xmit_d = XMIT_CONFIG;
    endcase
    link_ok_d = (state_d == LINK_OK);
  end

  // State, timer and pending-restart registers.
  always_ff @(posedge GTX_CLK or posedge mr_main_reset) begin
    if (mr_main_reset) begin
      state_q     <= LINK_DOWN;
      tmr_q       <= TMR_RELOAD;
      pend_down_q <= 1'b0;
      pend_cfg_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      pend_down_q <= pend_down_d;
      pend_cfg_q  <= pend_cfg_d;
    end
  end

  // Registered outputs, updated on the same edge as the state.
  always_ff @(posedge GTX_CLK or posedge mr_main_reset) begin
    if (mr_main_reset) begin
      xmit          <= XMIT_CONFIG;
      mr_link_ok    <= 1'b0;
      link_fail_cnt <= 8'd0;
    end else begin
      xmit          <= xmit_d;
      mr_link_ok    <= link_ok_d;
      link_fail_cnt <= fail_cnt_d;
    end
  end

  assign link_state = state_q;

endmodule

// File: tb/tb_pcs_link_ctrl.sv
// tb_pcs_link_ctrl: directed vector table, corner-case sequences and a
// randomized run against a cycle-level reference model of the link sequencer.

module tb_pcs_link_ctrl;

  localparam int LT = 16;
  localparam int CW = 8;

  logic       GTX_CLK = 1'b0;
  logic       mr_main_reset = 1'b1;
  logic       signal_detect = 1'b0;
  logic       code_sync_status = 1'b0;
  logic       mr_restart = 1'b0;
  logic       rx_config_det = 1'b0;
  logic       rx_idle_det = 1'b0;
  logic       transmitting = 1'b0;
  logic       receiving = 1'b0;
  logic [2:0] xmit;
  logic       mr_link_ok;
  logic [1:0] link_state;
  logic [7:0] link_fail_cnt;

  pcs_link_ctrl #(.LINK_TIMER(LT), .CNT_W(CW)) dut (
    .GTX_CLK          (GTX_CLK),
    .mr_main_reset    (mr_main_reset),
    .signal_detect    (signal_detect),
    .code_sync_status (code_sync_status),
    .mr_restart       (mr_restart),
    .rx_config_det    (rx_config_det),
    .rx_idle_det      (rx_idle_det),
    .transmitting     (transmitting),
    .receiving        (receiving),
    .xmit             (xmit),
    .mr_link_ok       (mr_link_ok),
    .link_state       (link_state),
    .link_fail_cnt    (link_fail_cnt)
  );

  always #5 GTX_CLK = ~GTX_CLK;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: mode number (0 down, 1 config, 2 idle, 3 ok), length of
  // the current qualifying run, deferred restart flags and exit count.
  int m_st, m_run, m_fc;
  bit m_pd, m_pc;

  task automatic m_reset();
    m_st = 0; m_run = 0; m_fc = 0; m_pd = 0; m_pc = 0;
  endtask

  task automatic m_step();
    bit up, busy, want_down, want_cfg, qualified;
    int nxt;
    if (mr_main_reset) begin
      m_reset();
      return;
    end
    up   = signal_detect & code_sync_status;
    busy = transmitting | receiving;
    nxt  = m_st;
    qualified = (m_st == 1 && rx_config_det) || (m_st == 2 && rx_idle_det);
    if (!up) nxt = 0;
    else if (mr_restart && m_st != 3) nxt = 0;
    else if (m_st == 0) nxt = 1;
    else if (m_st == 1) begin
      if (rx_config_det && m_run + 1 == LT) nxt = 2;
    end else if (m_st == 2) begin
      if (rx_config_det) nxt = 1;
      else if (rx_idle_det && m_run + 1 == LT) nxt = 3;
    end else begin
      want_down = mr_restart | m_pd;
      want_cfg  = rx_config_det | m_pc;
      if (!busy) begin
        if (want_down) nxt = 0;
        else if (want_cfg) nxt = 1;
      end else begin
        m_pd = want_down;
        m_pc = want_cfg;
      end
    end
    if (nxt != m_st) m_run = 0;
    else if (qualified) m_run = m_run + 1;
    else m_run = 0;
    if (nxt != 3) begin
      m_pd = 0;
      m_pc = 0;
    end
    if (m_st == 3 && nxt != 3 && m_fc < 255) m_fc = m_fc + 1;
    m_st = nxt;
  endtask

  function automatic logic [2:0] m_xmit();
    return (m_st == 3) ? 3'b100 : (m_st == 2) ? 3'b010 : 3'b001;
  endfunction

  task automatic tick();
    @(posedge GTX_CLK);
    m_step();
    #1;
  endtask

  task automatic drive(input bit sd, input bit cs, input bit rs, input bit cfg,
                       input bit idl, input bit tx, input bit rx);
    signal_detect = sd; code_sync_status = cs; mr_restart = rs;
    rx_config_det = cfg; rx_idle_det = idl; transmitting = tx; receiving = rx;
  endtask

  task automatic check_all(input string tag, input logic [2:0] xm, input logic [1:0] st,
                           input logic ok, input logic [7:0] fc);
    check({tag, " xmit"}, 32'(xmit), 32'(xm));
    check({tag, " link_state"}, 32'(link_state), 32'(st));
    check({tag, " mr_link_ok"}, 32'(mr_link_ok), 32'(ok));
    check({tag, " link_fail_cnt"}, 32'(link_fail_cnt), 32'(fc));
  endtask

  typedef struct {
    bit sd, cs, rs, cfg, idl, tx, rx;
    int n;
    logic [2:0] xm;
    logic [1:0] st;
    logic       ok;
    logic [7:0] fc;
  } vec_t;

  function automatic vec_t mk(input bit sd, input bit cs, input bit rs, input bit cfg,
                              input bit idl, input bit tx, input bit rx, input int n,
                              input logic [2:0] xm, input logic [1:0] st, input bit ok,
                              input int fc);
    vec_t v;
    v.sd = sd; v.cs = cs; v.rs = rs; v.cfg = cfg; v.idl = idl; v.tx = tx; v.rx = rx;
    v.n = n; v.xm = xm; v.st = st; v.ok = ok; v.fc = 8'(fc);
    return v;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[$];
    int exp_fc;
    int mode;

    //         sd cs rs cfg idl tx rx  n   xmit    st   ok fc
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,  2, 3'b001, 2'b00, 0, 0)); // no signal
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0,  1, 3'b001, 2'b01, 0, 0)); // up -> CONFIG_WAIT
    tbl.push_back(mk(1, 1, 0, 1, 0, 0, 0, 15, 3'b001, 2'b01, 0, 0)); // 15 of 16
    tbl.push_back(mk(1, 1, 0, 1, 0, 0, 0,  1, 3'b010, 2'b10, 0, 0)); // 16th -> IDLE
    tbl.push_back(mk(1, 1, 0, 0, 1, 0, 0, 15, 3'b010, 2'b10, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 1, 0, 0,  1, 3'b100, 2'b11, 1, 0)); // LINK_OK
    tbl.push_back(mk(1, 1, 1, 0, 1, 1, 0,  1, 3'b100, 2'b11, 1, 0)); // restart deferred
    tbl.push_back(mk(1, 1, 0, 0, 0, 1, 0,  3, 3'b100, 2'b11, 1, 0));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0,  1, 3'b001, 2'b00, 0, 1)); // frame ends
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0,  1, 3'b001, 2'b01, 0, 1));
    tbl.push_back(mk(1, 1, 0, 1, 0, 0, 0, 16, 3'b010, 2'b10, 0, 1));
    tbl.push_back(mk(1, 1, 0, 0, 1, 0, 0, 16, 3'b100, 2'b11, 1, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 0,  1, 3'b001, 2'b00, 0, 2)); // sync loss mid-frame
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0,  1, 3'b001, 2'b01, 0, 2));
    tbl.push_back(mk(1, 1, 0, 1, 0, 0, 0, 16, 3'b010, 2'b10, 0, 2));
    tbl.push_back(mk(1, 1, 0, 0, 1, 0, 0, 12, 3'b010, 2'b10, 0, 2)); // timer at 12
    tbl.push_back(mk(1, 1, 0, 1, 0, 0, 0,  1, 3'b001, 2'b01, 0, 2)); // partner /C/
    tbl.push_back(mk(1, 1, 0, 1, 0, 0, 0, 15, 3'b001, 2'b01, 0, 2)); // timer restarted
    tbl.push_back(mk(1, 1, 0, 1, 0, 0, 0,  1, 3'b010, 2'b10, 0, 2));
    tbl.push_back(mk(1, 1, 0, 0, 1, 0, 0, 16, 3'b100, 2'b11, 1, 2));
    tbl.push_back(mk(1, 1, 0, 1, 0, 0, 0,  1, 3'b001, 2'b01, 0, 3)); // /C/ in idle LINK_OK
    tbl.push_back(mk(1, 1, 0, 1, 0, 0, 0, 16, 3'b010, 2'b10, 0, 3));
    tbl.push_back(mk(1, 1, 0, 0, 1, 0, 0, 16, 3'b100, 2'b11, 1, 3));
    tbl.push_back(mk(1, 1, 0, 1, 1, 0, 1,  1, 3'b100, 2'b11, 1, 3)); // /C/ deferred
    tbl.push_back(mk(1, 1, 1, 0, 1, 0, 1,  1, 3'b100, 2'b11, 1, 3)); // restart deferred too
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0,  1, 3'b001, 2'b00, 0, 4)); // LINK_DOWN wins
    tbl.push_back(mk(1, 1, 1, 0, 0, 0, 0,  3, 3'b001, 2'b00, 0, 4)); // restart held
    tbl.push_back(mk(1, 1, 0, 1, 0, 0, 0,  1, 3'b001, 2'b01, 0, 4));
    tbl.push_back(mk(1, 1, 1, 1, 0, 0, 0,  1, 3'b001, 2'b00, 0, 4)); // restart in CONFIG_WAIT

    m_reset();
    repeat (3) tick();
    check_all("reset", 3'b001, 2'b00, 1'b0, 8'd0);
    mr_main_reset = 1'b0;

    foreach (tbl[i]) begin
      drive(tbl[i].sd, tbl[i].cs, tbl[i].rs, tbl[i].cfg, tbl[i].idl, tbl[i].tx, tbl[i].rx);
      repeat (tbl[i].n) tick();
      check_all($sformatf("vec%0d", i), tbl[i].xm, tbl[i].st, tbl[i].ok, tbl[i].fc);
    end

    // Timer restart: 10 high, 1 low, 15 high stays put; one more advances.
    drive(1, 1, 0, 0, 0, 0, 0); tick();
    check("trst enter", 32'(link_state), 32'd1);
    drive(1, 1, 0, 1, 0, 0, 0); repeat (10) tick();
    drive(1, 1, 0, 0, 0, 0, 0); tick();
    drive(1, 1, 0, 1, 0, 0, 0); repeat (15) tick();
    check("trst hold state", 32'(link_state), 32'd1);
    check("trst hold xmit", 32'(xmit), 32'd1);
    tick();
    check("trst adv state", 32'(link_state), 32'd2);
    check("trst adv xmit", 32'(xmit), 32'd2);

    // Saturation of the exit counter.
    drive(0, 0, 0, 0, 0, 0, 0); tick();
    exp_fc = 4;
    for (int k = 1; k <= 256; k++) begin
      drive(1, 1, 0, 0, 0, 0, 0); tick();
      drive(1, 1, 0, 1, 0, 0, 0); repeat (LT) tick();
      drive(1, 1, 0, 0, 1, 0, 0); repeat (LT) tick();
      drive(0, 1, 0, 0, 0, 1, 0); tick();
      exp_fc = (exp_fc == 255) ? 255 : exp_fc + 1;
      check($sformatf("sat iter%0d", k), 32'(link_fail_cnt), 32'(exp_fc));
    end

    // Async reset mid-frame in LINK_OK, asserted between edges.
    drive(1, 1, 0, 0, 0, 0, 0); tick();
    drive(1, 1, 0, 1, 0, 0, 0); repeat (LT) tick();
    drive(1, 1, 0, 0, 1, 0, 0); repeat (LT) tick();
    drive(1, 1, 0, 0, 1, 1, 0); repeat (2) tick();
    check("pre-areset link_ok", 32'(mr_link_ok), 32'd1);
    #2;
    mr_main_reset = 1'b1;
    #1;
    m_reset();
    check_all("areset", 3'b001, 2'b00, 1'b0, 8'd0);
    tick();
    check_all("areset held", 3'b001, 2'b00, 1'b0, 8'd0);
    mr_main_reset = 1'b0;

    // Randomized run against the reference model.
    mode = 0;
    for (int c = 0; c < 4000; c++) begin
      if (c % 40 == 0) mode = $urandom_range(0, 2);
      signal_detect    = ($urandom_range(0, 99) != 0);
      code_sync_status = ($urandom_range(0, 99) != 0);
      mr_restart       = ($urandom_range(0, 149) == 0);
      case (mode)
        0: begin
          rx_config_det = ($urandom_range(0, 19) != 0);
          rx_idle_det   = ($urandom_range(0, 9) == 0);
        end
        1: begin
          rx_config_det = ($urandom_range(0, 59) == 0);
          rx_idle_det   = ($urandom_range(0, 19) != 0);
        end
        default: begin
          rx_config_det = ($urandom_range(0, 29) == 0);
          rx_idle_det   = 1'b1;
        end
      endcase
      transmitting = ($urandom_range(0, 1) == 1);
      receiving    = ($urandom_range(0, 3) == 0);
      tick();
      check_all($sformatf("rand%0d", c), m_xmit(), 2'(m_st), (m_st == 3), 8'(m_fc));
      check($sformatf("rand%0d onehot", c), 32'($onehot(xmit)), 32'd1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pcs_link_ctrl.md
Name: pcs_link_ctrl

Overview:
Link-bring-up sequencer for the 1000BASE-X PCS. It drives the shared `xmit` mode bus (CONFIG/IDLE/DATA) into the transmit and receive sublayers. Decisions use synchronization status, signal detect and ordered-set detect flags from the receive path. Mode changes away from DATA are deferred while a frame is in flight, so `xmit` never truncates a packet except on loss of sync.

Parameters:
LINK_TIMER, 1024, consecutive qualifying cycles required in CONFIG_WAIT and IDLE_DETECT (min 2)
CNT_W, 20, timer width; must satisfy 2^CNT_W > LINK_TIMER

Ports:
GTX_CLK  input  1  PCS clock; all state changes on rising edge
mr_main_reset  input  1  asynchronous, active-high reset
signal_detect  input  1  PMD signal present
code_sync_status  input  1  synchronizer lock
mr_restart  input  1  management restart request, level, sampled each cycle
rx_config_det  input  1  receiver currently seeing /C/ ordered sets
rx_idle_det  input  1  receiver currently seeing /I/ ordered sets
transmitting  input  1  transmit path mid-frame
receiving  input  1  receive path mid-frame
xmit  output  3  one-hot mode: 3'b001 CONFIG, 3'b010 IDLE, 3'b100 DATA
mr_link_ok  output  1  high only in LINK_OK
link_state  output  2  00 LINK_DOWN, 01 CONFIG_WAIT, 10 IDLE_DETECT, 11 LINK_OK
link_fail_cnt  output  8  saturating count of exits from LINK_OK

Behaviour:
- Reset (async assert, sync release): state LINK_DOWN, xmit=001, mr_link_ok=0, link_state=00, timer=0, restart_pending=0, link_fail_cnt=0.
- All outputs are registered and updated on the same edge as the state, so they reflect the new state one cycle after the causing input.
- Define `up = signal_detect & code_sync_status`.
- Timer rules:
  - Cleared on every state entry.
  - In a timed state, increments while the qualifying input is high.
  - Cleared when the qualifying input is low.
  - Expiry occurs when timer==LINK_TIMER-1 and the input is high. Expiry means exactly LINK_TIMER consecutive qualifying cycles.
- LINK_DOWN (xmit=CONFIG): if up → CONFIG_WAIT.
- CONFIG_WAIT (xmit=CONFIG):
  - Qualifier is rx_config_det.
  - On expiry → IDLE_DETECT.
- IDLE_DETECT (xmit=IDLE):
  - Qualifier is rx_idle_det.
  - rx_config_det=1 → CONFIG_WAIT. This takes priority over expiry.
  - On expiry → LINK_OK.
- LINK_OK (xmit=DATA, mr_link_ok=1):
  - A restart event is mr_restart=1 or rx_config_det=1.
  - If transmitting|receiving is 0, a restart event takes effect immediately.
  - Otherwise restart_pending is set and the transition occurs on the first cycle transmitting|receiving is 0.
  - Target is LINK_DOWN for mr_restart and CONFIG_WAIT for rx_config_det. If both occurred, LINK_DOWN wins.
- Global priority, highest first:
  1. !up → LINK_DOWN immediately from any state; not deferred, even mid-frame; clears restart_pending.
  2. mr_restart outside LINK_OK → LINK_DOWN immediately.
  3. State-local rules.
- mr_restart held high keeps the block in LINK_DOWN. The up→CONFIG_WAIT step requires mr_restart=0.
- link_fail_cnt increments by 1 on every transition out of LINK_OK for any cause. It saturates at 255 and never wraps.
- restart_pending is cleared on leaving LINK_OK.
- Reset asserted mid-operation, including mid-frame: immediate return to reset values; no deferral.
- xmit is always exactly one-hot; no other encoding is ever driven.

Test Plan:
(LINK_TIMER=16 for all scenarios)
- Bring-up: release reset, up=1, rx_config_det=1 for 16 cycles, then rx_idle_det=1 for 16 cycles → xmit 001→010→100. IDLE_DETECT is entered exactly 16 cycles after CONFIG_WAIT entry; mr_link_ok rises 16 cycles after IDLE_DETECT entry; link_state=11.
- Timer restart: in CONFIG_WAIT, rx_config_det high 10 cycles, low 1, high 15 → still CONFIG_WAIT, xmit=001. One more high cycle → IDLE_DETECT.
- Deferred restart: in LINK_OK, transmitting=1, pulse mr_restart 1 cycle → xmit stays 100. transmitting falls at cycle T → LINK_DOWN at T+1, xmit=001, link_fail_cnt=1.
- Sync loss mid-frame: in LINK_OK with transmitting=1, drop code_sync_status → LINK_DOWN next edge, mr_link_ok=0, link_fail_cnt increments.
- Partner restart: in IDLE_DETECT at timer=12, assert rx_config_det → CONFIG_WAIT, timer 0. In LINK_OK (idle), assert rx_config_det → CONFIG_WAIT, xmit=001.
- Saturation and async reset: force 260 LINK_OK exits → link_fail_cnt=255. Assert mr_main_reset between edges → all outputs at reset values before the next GTX_CLK edge.
